banked_data_memory: RTL and testbench

//  Parametrised banked data memory for the processor load/store path; generalises the 4-bank manager.

---
 rtl/banked_data_memory.sv | 188 ++++++++++++++++++
 tb/tb_banked_data_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_data_memory.sv
// Banked data memory for the load/store path: decodes a byte address into
// bank/word/lane, performs byte/halfword/word accesses with sign or zero
// extension, flags misaligned/illegal/out-of-range accesses, and answers each
// accepted request with a single rvalid_o pulse after a fixed latency.
module banked_data_memory #(
    parameter int unsigned NUM_BANKS  = 16,
    parameter int unsigned DEPTH      = 2**14,
    parameter int unsigned BANK_LSB   = 18,
    parameter int unsigned RD_LATENCY = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        wren_i,
    input  logic [1:0]  byte_mode_i,
    input  logic        sign_i,
    input  logic [31:0] address_i,
    input  logic [31:0] data_i,
    output logic        rvalid_o,
    output logic [31:0] data_o,
    output logic        err_o
);

    localparam int unsigned BW       = $clog2(NUM_BANKS);
    localparam int unsigned WW       = $clog2(DEPTH);
    localparam int unsigned HI_LSB   = BANK_LSB + BW;
    localparam int unsigned CW       = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    // WAIT lasts RD_LATENCY-1 cycles so that RESP lands RD_LATENCY cycles after acceptance
    localparam int unsigned CNT_INIT = (RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    res_q;
    logic           rerr_q;

    logic [BW-1:0]  bank_c;
    logic [WW-1:0]  word_c;
    logic [1:0]     lane_c;
    logic           oor_c;
    logic           mis_c;
    logic           err_c;
    logic           accept_c;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c;
    logic [31:0]    rword_c;
    logic [31:0]    shifted_c;
    logic [31:0]    load_c;
    logic [31:0]    result_c;
    logic [31:0]    bank_word [NUM_BANKS];
    logic           unused_addr_c;

    // Address decode and request classification
    always_comb begin
        bank_c   = address_i[BANK_LSB +: BW];
        word_c   = address_i[2 +: WW];
        lane_c   = address_i[1:0];
        oor_c    = (address_i >> HI_LSB) != 32'd0;
        accept_c = req_i && ready_o;
        mis_c    = 1'b0;
        case (byte_mode_i)
            MODE_BYTE: mis_c = 1'b0;
            MODE_HALF: mis_c = lane_c[0];
            MODE_WORD: mis_c = (lane_c != 2'd0);
            default:   mis_c = 1'b1;
        endcase
        err_c = mis_c || oor_c;
    end

    // Aliased address bits are intentionally don't-care
    assign unused_addr_c = ^address_i;

    // Byte enables and lane-replicated store data
    always_comb begin
        be_c    = 4'hF;
        wdata_c = data_i;
        case (byte_mode_i)
            MODE_BYTE: begin
                be_c    = 4'(4'b0001 << lane_c);
                wdata_c = {4{data_i[7:0]}};
            end
            MODE_HALF: begin
                be_c    = 4'(4'b0011 << lane_c);
                wdata_c = {2{data_i[15:0]}};
            end
            default: begin
                be_c    = 4'hF;
                wdata_c = data_i;
            end
        endcase
    end

    // Per-bank storage: byte-enabled write and read of the addressed word
    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        logic [31:0] mem [DEPTH];

        // Store into this bank on the accepting edge
        always_ff @(posedge clk) begin
            if (accept_c && wren_i && !err_c && (bank_c == BW'(b))) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_c[k]) begin
                        mem[word_c][8*k +: 8] <= wdata_c[8*k +: 8];
                    end
                end
            end
        end

        assign bank_word[b] = mem[word_c];
    end

    // Load alignment and extension of the addressed word
    always_comb begin
        rword_c   = bank_word[bank_c];
        shifted_c = rword_c >> {lane_c, 3'b000};
        case (byte_mode_i)
            MODE_BYTE: load_c = {{24{sign_i & shifted_c[7]}},  shifted_c[7:0]};
            MODE_HALF: load_c = {{16{sign_i & shifted_c[15]}}, shifted_c[15:0]};
            default:   load_c = shifted_c;
        endcase
        result_c = (err_c || wren_i) ? 32'd0 : load_c;
    end

    // Handshake FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            res_q    <= '0;
            rerr_q   <= 1'b0;
            ready_o  <= 1'b1;
            rvalid_o <= 1'b0;
            data_o   <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            data_o   <= '0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        res_q   <= result_c;
                        rerr_q  <= err_c;
                        ready_o <= 1'b0;
                        if (RD_LATENCY == 1) begin
                            state    <= RESP;
                            rvalid_o <= 1'b1;
                            data_o   <= result_c;
                            err_o    <= err_c;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(CNT_INIT);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= RESP;
                        rvalid_o <= 1'b1;
                        data_o   <= res_q;
                        err_o    <= rerr_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_data_memory.sv
// Randomized self-checking bench for banked_data_memory with a byte-level
// reference memory and a latency countdown model.
module tb_banked_data_memory;

    localparam int unsigned L   = 3;
    localparam int unsigned NB  = 16;
    localparam int unsigned DEP = 2**14;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        ready;
    logic        wren;
    logic [1:0]  mode;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    banked_data_memory #(
        .NUM_BANKS (NB),
        .DEPTH     (DEP),
        .BANK_LSB  (18),
        .RD_LATENCY(L),
        .INIT_FILE ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .ready_o    (ready),
        .wren_i     (wren),
        .byte_mode_i(mode),
        .sign_i     (sign),
        .address_i  (addr),
        .data_i     (wdata),
        .rvalid_o   (rvalid),
        .data_o     (rdata),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [7:0]  mb [int];
    int          rem;
    logic [31:0] exp_data;
    logic        exp_err;
    int          total;
    int          bad;
    logic [31:0] last_data;
    logic        last_err;
    int          resp_step;
    int          step_no;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply the specification's access rules to the byte-level reference memory
    task automatic model_accept();
        int unsigned bank, word, lane, n, base;
        logic [31:0] v;
        bank = (addr >> 18) & (NB - 1);
        word = (addr >> 2) & (DEP - 1);
        lane = addr & 3;
        n    = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
        base = (bank * DEP + word) * 4;
        exp_err = (mode == 2'd3) || (mode == 2'd1 && (lane % 2) == 1) ||
                  (mode == 2'd2 && lane != 0) || ((addr >> 22) != 0);
        exp_data = 32'd0;
        if (!exp_err) begin
            if (wren) begin
                for (int k = 0; k < int'(n); k++) mb[int'(base + lane) + k] = 8'(wdata >> (8 * k));
            end else begin
                v = 32'd0;
                for (int k = 0; k < int'(n); k++) v = v | (32'(mb[int'(base + lane) + k]) << (8 * k));
                if (sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                exp_data = v;
            end
        end
    endtask

    // One clock: advance model on the edge, compare outputs on the falling edge
    task automatic step();
        @(posedge clk);
        if (!rst_n) rem = 0;
        else if (req && rem == 0) begin
            model_accept();
            rem = L;
        end else if (rem > 0) rem--;
        @(negedge clk);
        step_no++;
        check("ready", 32'(ready), 32'(rem == 0));
        check("rvalid", 32'(rvalid), 32'(rem == 1));
        check("data", rdata, (rem == 1) ? exp_data : 32'd0);
        check("err", 32'(err), (rem == 1) ? 32'(exp_err) : 32'd0);
        if (rvalid) begin
            last_data = rdata;
            last_err  = err;
            resp_step = step_no;
        end
    endtask

    task automatic scramble();
        wren  = 1'($urandom);
        mode  = 2'($urandom);
        sign  = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // Full transaction; inputs are scrambled while busy to show they are ignored
    task automatic xact(input logic w, input logic [1:0] m, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
        int start, n;
        req = 1'b1; wren = w; mode = m; sign = s; addr = a; wdata = d;
        start = step_no;
        step();
        n = 0;
        while (rem > 0 && n < 20) begin
            req = hold;
            scramble();
            step();
            n++;
        end
        if (rem > 0) check("timeout", 32'(rem), 32'd0);
        check("rv_at", 32'(resp_step - start), 32'(L));
        check("tput", 32'(step_no - start), 32'(L + 1));
        req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned banks [3] = '{0, 1, 15};
        logic [31:0] a;
        a = (32'(banks[$urandom % 3]) << 18) | (32'($urandom % 8) << 2) |
            (32'($urandom % 4) << 16) | 32'($urandom % 4);
        if ($urandom % 16 == 0) a = a | (32'd1 << (22 + $urandom % 10));
        return a;
    endfunction

    initial begin
        int unsigned pb [3] = '{0, 1, 15};
        total = 0; bad = 0; rem = 0; step_no = 0; resp_step = 0;
        last_data = '0; last_err = 1'b0; exp_data = '0; exp_err = 1'b0;
        rst_n = 1'b0; req = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();

        // Preload the words the bench touches
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 8; w++)
                xact(1'b1, 2'd2, 1'b0, (32'(pb[i]) << 18) | (32'(w) << 2), $urandom, 1'b0);

        // Word store / load
        xact(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        xact(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("t1_data", last_data, 32'hDEAD_BEEF);
        check("t1_err", 32'(last_err), 32'd0);

        // Byte store into bank 1, signed/unsigned reload, neighbour lanes intact
        xact(1'b1, 2'd2, 1'b0, 32'h0004_0010, 32'h1122_3344, 1'b0);
        xact(1'b1, 2'd0, 1'b0, 32'h0004_0013, 32'h0000_0080, 1'b0);
        xact(1'b0, 2'd0, 1'b1, 32'h0004_0013, 32'h0, 1'b0);
        check("t2_sbyte", last_data, 32'hFFFF_FF80);
        xact(1'b0, 2'd0, 1'b0, 32'h0004_0013, 32'h0, 1'b0);
        check("t2_ubyte", last_data, 32'h0000_0080);
        xact(1'b0, 2'd2, 1'b0, 32'h0004_0010, 32'h0, 1'b0);
        check("t2_word", last_data, 32'h8022_3344);

        // Misaligned and illegal accesses
        xact(1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0, 1'b0);
        check("t3_half_err", 32'(last_err), 32'd1);
        check("t3_half_data", last_data, 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h0, 1'b0);
        check("t3_word_err", 32'(last_err), 32'd1);
        xact(1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
        check("t3_ill_err", 32'(last_err), 32'd1);
        xact(1'b1, 2'd2, 1'b0, 32'h0000_0011, 32'h0BAD_0BAD, 1'b0);
        xact(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("t3_unchanged", last_data, 32'hDEAD_BEEF);

        // Out of range, bank independence, aliasing of ignored bits
        xact(1'b0, 2'd2, 1'b0, 32'h0040_0000, 32'h0, 1'b0);
        check("t4_oor", 32'(last_err), 32'd1);
        xact(1'b1, 2'd2, 1'b0, 32'h003C_0010, 32'hCAFE_F00D, 1'b0);
        xact(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("t4_bank0", last_data, 32'hDEAD_BEEF);
        xact(1'b0, 2'd2, 1'b0, 32'h003C_0010, 32'h0, 1'b0);
        check("t4_bank15", last_data, 32'hCAFE_F00D);
        xact(1'b0, 2'd2, 1'b0, 32'h0003_0010, 32'h0, 1'b0);
        check("t4_alias", last_data, 32'hDEAD_BEEF);

        // Back-to-back with req held high
        xact(1'b0, 2'd1, 1'b1, 32'h0004_0012, 32'h0, 1'b1);
        xact(1'b0, 2'd2, 1'b0, 32'h003C_0010, 32'h0, 1'b1);
        check("t5_data", last_data, 32'hCAFE_F00D);

        // Reset during WAIT drops the request
        req = 1'b1; wren = 1'b0; mode = 2'd2; sign = 1'b0; addr = 32'h0000_0010;
        step();
        req = 1'b0;
        rst_n = 1'b0;
        rem = 0;
        #1;
        check("t6_rst_ready", 32'(ready), 32'd1);
        check("t6_rst_rvalid", 32'(rvalid), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        xact(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("t6_data", last_data, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 4 == 0) begin
                req = 1'b0;
                scramble();
                step();
            end else begin
                xact(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom, 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
